mul_shiftadd: RTL and testbench

Iterative radix-2 shift-add multiplier, the inverse-operation companion to the subtract-shift divider in the same arithmetic library. It uses the same `en`/`done`/`sign` start-hold handshake as the divider, so a controller can drive either unit through identical sequencing. It produces a full-width registered product and is the block of choice wherever area matters more than throughput.

---
 rtl/mul_shiftadd.sv | 117 +++++++++++
 tb/tb_mul_shiftadd.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_shiftadd.sv
// Iterative radix-2 shift-add multiplier with en/done start-hold handshake.
// Define MUL_SHIFTADD_SIGNED_EN to honour `sign` (two's complement operands, extra FIX state).
module mul_shiftadd #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sign,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic [2*DATA_W-1:0]   product,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    mcand;
    // High half accumulates partial products; low half holds the multiplier as it shifts out.
    logic [2*DATA_W-1:0]  acc;

    function automatic logic [2*DATA_W-1:0] shift_add(input logic [2*DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0]   m);
        logic [DATA_W:0] hi;
        hi = {1'b0, a[2*DATA_W-1:DATA_W]} + (a[0] ? {1'b0, m} : '0);
        return {hi, a[DATA_W-1:1]};
    endfunction

`ifdef MUL_SHIFTADD_SIGNED_EN
    logic neg;

    // |-2^(DATA_W-1)| wraps back to 2^(DATA_W-1), which is exact as an unsigned value.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate(input logic [2*DATA_W-1:0] v);
        return ~v + (2*DATA_W)'(1);
    endfunction
`else
    logic unused_sign;
    assign unused_sign = sign;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
`ifdef MUL_SHIFTADD_SIGNED_EN
                        mcand <= magnitude(op_a, sign);
                        acc   <= {{DATA_W{1'b0}}, magnitude(op_b, sign)};
                        neg   <= sign & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
`else
                        mcand <= op_a;
                        acc   <= {{DATA_W{1'b0}}, op_b};
`endif
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        acc <= shift_add(acc, mcand);
                        cnt <= cnt + CNT_W'(1);
                    end else begin
`ifdef MUL_SHIFTADD_SIGNED_EN
                        state <= ST_FIX;
`else
                        product <= acc;
                        done    <= 1'b1;
                        state   <= ST_DONE;
`endif
                    end
                end
                ST_FIX: begin
`ifdef MUL_SHIFTADD_SIGNED_EN
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        product <= neg ? negate(acc) : acc;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    // Stays here while en is held so a long hold never retriggers.
                    if (!en) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_shiftadd.sv
// Scoreboard bench for mul_shiftadd at DATA_W=16; expected products and latency queued at issue.
module tb_mul_shiftadd;

    localparam int W = 16;
`ifdef MUL_SHIFTADD_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic           clk;
    logic           rst;
    logic           en;
    logic           sign;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] product;
    logic           done;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start;
        string          name;
    } exp_t;

    exp_t sbq[$];
    int   cyc;
    int   tests;
    int   fails;
    logic done_q;

    mul_shiftadd #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .sign(sign),
        .op_a(op_a), .op_b(op_b), .product(product), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising done must match the oldest queued expectation.
    initial begin
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no result", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    tests++;
                    if (product !== e.prod) begin
                        fails++;
                        $display("FAIL %s product: got %h, required %h", e.name, product, e.prod);
                    end
                    tests++;
                    if (cyc - e.start != LAT) begin
                        fails++;
                        $display("FAIL %s latency: got %0d, required %0d", e.name, cyc - e.start, LAT);
                    end
                end
            end
            done_q = done;
        end
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [2*W-1:0] exp_p, input string nm, input bit push);
        exp_t e;
        op_a = a; op_b = b; sign = s; en = 1'b1;
        if (push) begin
            e.prod = exp_p; e.start = cyc + 1; e.name = nm;
            sbq.push_back(e);
        end
    endtask

    task automatic finish_op(input string nm, input int hold);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", nm, done, n);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL %s hold%0d: done=%b, required 1", nm, i, done);
            end
        end
        en = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s done_fall: done=%b, required 0", nm, done);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp_p, input string nm, input int hold);
        start_op(a, b, s, exp_p, nm, 1'b1);
        @(negedge clk);
        finish_op(nm, hold);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1; en = 1'b0; sign = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
        tests++;
        if (product !== 32'h0) begin fails++; $display("FAIL reset_product: got %h, required 0", product); end
        @(negedge clk);

        run_op(16'd3,    16'd5,    1'b0, 32'h0000000F, "u_3x5", 10);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_max", 1);
        run_op(16'h0000, 16'hABCD, 1'b0, 32'h00000000, "u_zero", 1);
        run_op(16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, "u_fffd_x7", 0);
        run_op(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, "u_ff_x101", 0);
`ifdef MUL_SHIFTADD_SIGNED_EN
        run_op(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "s_m3x7", 0);
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_minxmin", 0);
        run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s_minx1", 0);
        run_op(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, "s_maxsq", 0);
`else
        run_op(16'hFFFD, 16'h0007, 1'b1, 32'h0006FFEB, "ns_m3x7", 0);
        run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "ns_minxmin", 0);
        run_op(16'h8000, 16'h0001, 1'b1, 32'h00008000, "ns_minx1", 0);
        run_op(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, "ns_maxsq", 0);
`endif

        // Abort mid-run: product must keep the previous result (0x3FFF0001).
        start_op(16'd100, 16'd200, 1'b0, 32'h0, "abort", 1'b0);
        repeat (8) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b, required 0", done); end
        tests++;
        if (product !== 32'h3FFF0001) begin
            fails++; $display("FAIL abort_product: got %h, required 3fff0001", product);
        end
        run_op(16'd2, 16'd2, 1'b0, 32'h00000004, "after_abort", 0);

        // Reset mid-run with en still high restarts on the operands present after reset.
        start_op(16'd9, 16'd9, 1'b0, 32'h0, "pre_rst", 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b, required 0", done); end
        tests++;
        if (product !== 32'h0) begin fails++; $display("FAIL rst_mid_product: got %h, required 0", product); end
        start_op(16'd6, 16'd7, 1'b0, 32'h0000002A, "post_rst", 1'b1);
        @(negedge clk);
        finish_op("post_rst", 0);

        repeat (3) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++; $display("FAIL scoreboard_empty: %0d pending, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
